// File: rtl/add_sub_checker_if.sv
// Stimulus/result bundle between a stimulus source and the add_sub response checker.
// The master drives the sampled add_sub operands/outputs plus run control;
// the slave (the checker) returns run status, counters and the first-failure capture.
interface add_sub_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  // run control and sampled add_sub traffic
  logic             start;
  logic             done;
  logic             valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] r;
  logic             cout;

  // status, counters and first-failure capture
  logic             busy;
  logic             finished;
  logic             err_flag;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic             fail_cin;
  logic [WIDTH-1:0] fail_r;
  logic             fail_cout;
  logic [WIDTH-1:0] exp_r;
  logic             exp_cout;

  modport master (
    output start, done, valid, a, b, cin, r, cout,
    input  busy, finished, err_flag, pass_cnt, err_cnt,
           fail_a, fail_b, fail_cin, fail_r, fail_cout, exp_r, exp_cout
  );

  modport slave (
    input  start, done, valid, a, b, cin, r, cout,
    output busy, finished, err_flag, pass_cnt, err_cnt,
           fail_a, fail_b, fail_cin, fail_r, fail_cout, exp_r, exp_cout
  );
endinterface

// File: rtl/add_sub_checker.sv
// Response checker for the add_sub unit. Samples operands and the unit's
// result in stage 1, recomputes the golden add/subtract in stage 2 and keeps
// saturating pass/error counts plus a capture of the first failing vector.
module add_sub_checker #(
  parameter int WIDTH       = 4,
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  add_sub_checker_if.slave  io
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_HALT
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic             finished_q;

  // stage 1: sampled vector
  logic             s1_vld_q;
  logic             s1_vld_d;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_cin_q;
  logic [WIDTH-1:0] s1_r_q;
  logic             s1_cout_q;

  // stage 2: counters and capture
  logic             err_flag_q;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] pass_cnt_d;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_b_q;
  logic             fail_cin_q;
  logic [WIDTH-1:0] fail_r_q;
  logic             fail_cout_q;
  logic [WIDTH-1:0] exp_r_q;
  logic             exp_cout_q;

  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   exp_sum;
  logic             cmp_en;
  logic             mismatch;
  logic             halt_go;

  // Golden result and compare enables for the stage-1 sample.
  // Subtract is a + ~b + 1, so the carry-out reads as "no borrow".
  always_comb begin
    op_b       = s1_cin_q ? ~s1_b_q : s1_b_q;
    exp_sum    = {1'b0, s1_a_q} + {1'b0, op_b} + {{WIDTH{1'b0}}, s1_cin_q};
    mismatch   = (exp_sum != {s1_cout_q, s1_r_q});
    // start wins over everything: the in-flight sample is dropped, not judged
    cmp_en     = s1_vld_q && !io.start &&
                 ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    // a failure seen while draining is recorded but never halts
    halt_go    = STOP_ON_ERR && cmp_en && mismatch && (state_q == ST_RUN);
    s1_vld_d   = (state_q == ST_RUN) && io.valid && !io.start && !halt_go;
    pass_cnt_d = (pass_cnt_q == {CNT_W{1'b1}}) ? pass_cnt_q : pass_cnt_q + CNT_W'(1);
    err_cnt_d  = (err_cnt_q  == {CNT_W{1'b1}}) ? err_cnt_q  : err_cnt_q  + CNT_W'(1);
  end

  // Run-control FSM with registered busy/finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else if (io.start) begin
      state_q    <= ST_RUN;
      busy_q     <= 1'b1;
      finished_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_go) begin
            state_q    <= ST_HALT;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
          end else if (io.done) begin
            state_q    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_q    <= ST_DONE;
          busy_q     <= 1'b0;
          finished_q <= 1'b1;
        end
        default: ;  // IDLE/DONE/HALT wait for start
      endcase
    end
  end

  // Stage 1: capture the live sample while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_cin_q  <= 1'b0;
      s1_r_q    <= '0;
      s1_cout_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (s1_vld_d) begin
        s1_a_q    <= io.a;
        s1_b_q    <= io.b;
        s1_cin_q  <= io.cin;
        s1_r_q    <= io.r;
        s1_cout_q <= io.cout;
      end
    end
  end

  // Stage 2: saturating counters, sticky error flag, first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag_q  <= 1'b0;
      pass_cnt_q  <= '0;
      err_cnt_q   <= '0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_cin_q  <= 1'b0;
      fail_r_q    <= '0;
      fail_cout_q <= 1'b0;
      exp_r_q     <= '0;
      exp_cout_q  <= 1'b0;
    end else if (io.start) begin
      err_flag_q  <= 1'b0;
      pass_cnt_q  <= '0;
      err_cnt_q   <= '0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_cin_q  <= 1'b0;
      fail_r_q    <= '0;
      fail_cout_q <= 1'b0;
      exp_r_q     <= '0;
      exp_cout_q  <= 1'b0;
    end else if (cmp_en) begin
      if (mismatch) begin
        err_cnt_q  <= err_cnt_d;
        err_flag_q <= 1'b1;
        if (!err_flag_q) begin
          fail_a_q    <= s1_a_q;
          fail_b_q    <= s1_b_q;
          fail_cin_q  <= s1_cin_q;
          fail_r_q    <= s1_r_q;
          fail_cout_q <= s1_cout_q;
          exp_r_q     <= exp_sum[WIDTH-1:0];
          exp_cout_q  <= exp_sum[WIDTH];
        end
      end else begin
        pass_cnt_q <= pass_cnt_d;
      end
    end
  end

  assign io.busy      = busy_q;
  assign io.finished  = finished_q;
  assign io.err_flag  = err_flag_q;
  assign io.pass_cnt  = pass_cnt_q;
  assign io.err_cnt   = err_cnt_q;
  assign io.fail_a    = fail_a_q;
  assign io.fail_b    = fail_b_q;
  assign io.fail_cin  = fail_cin_q;
  assign io.fail_r    = fail_r_q;
  assign io.fail_cout = fail_cout_q;
  assign io.exp_r     = exp_r_q;
  assign io.exp_cout  = exp_cout_q;

endmodule

// File: doc/add_sub_checker.md
# add_sub_checker

On-chip response checker for the 4-bit `add_sub` unit, sitting on the result side of the adder/subtractor. It samples the operands driven into `add_sub` together with the unit's `R`/`Cout` outputs and recomputes the golden result. It counts passes and mismatches, captures the first failing vector, and reports run status, so stimulus sequences can be self-checked in hardware and in simulation.

## Interface
- `WIDTH`, 4: operand/result width.
- `CNT_W`, 8: pass/error counter width.
- `STOP_ON_ERR`, 0: when 1, the first mismatch halts checking.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle pulse; clears counters and capture, begins a run.
- `done` input 1: one-cycle pulse; ends the run after the pipeline drains.
- `valid` input 1: the sample on `a`/`b`/`cin`/`r`/`cout` is live this cycle.
- `a`, `b` input WIDTH: operands as applied to `add_sub`.
- `cin` input 1: mode; 0 = add, 1 = subtract.
- `r` input WIDTH, `cout` input 1: `add_sub` outputs for that sample.
- `busy` output 1: run in progress (RUN or DRAIN).
- `finished` output 1: run complete (DONE or HALT).
- `err_flag` output 1: at least one mismatch this run.
- `pass_cnt`, `err_cnt` output CNT_W: saturating counts.
- `fail_a`, `fail_b` output WIDTH, `fail_cin` output 1: first failing operands.
- `fail_r` output WIDTH, `fail_cout` output 1: observed result of first failure.
- `exp_r` output WIDTH, `exp_cout` output 1: expected result of first failure.

## Operation
- Golden model, WIDTH+1-bit arithmetic:
  - `cin`=0: {exp_cout, exp_r} = a + b.
  - `cin`=1: {exp_cout, exp_r} = a + ~b + 1, so `exp_cout`=1 means no borrow (a ≥ b).
- Two-stage pipeline:
  - Stage 1 registers `valid`, `a`, `b`, `cin`, `r`, `cout` when in RUN.
  - Stage 2 computes the golden result from the stage-1 registers, compares both `r` and `cout`, and updates counters and capture.
- FSM states:
  - IDLE: `start` → RUN.
  - RUN: `done` → DRAIN; mismatch with STOP_ON_ERR=1 → HALT.
  - DRAIN: one cycle, completes the compare of the last stage-1 sample, then → DONE. That compare counts normally and may capture a first failure, but does not go to HALT.
  - DONE: `start` → RUN with a fresh run.
  - HALT: `start` → RUN with a fresh run.
- Samples with `valid` high outside RUN are ignored.
- `start` clears `pass_cnt`, `err_cnt`, `err_flag`, all `fail_*`/`exp_*` outputs and stage 1. If `start` arrives in RUN or DRAIN, it restarts the run and the in-flight sample is discarded.
- `start` and `done` in the same cycle: `start` wins.
- Counters saturate at 2^CNT_W−1 and never wrap. `err_flag` stays set even when `err_cnt` is saturated.
- Capture registers load only on the first mismatch of a run and then hold.
- With STOP_ON_ERR=1, the failing sample is counted and captured. The next-cycle sample in stage 1 is discarded, and no further compares occur.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `finished`=0, `err_flag`=0, all counters 0, all `fail_*`/`exp_*` 0, FSM in IDLE, stage-1 valid 0.
- Reset asserted mid-run forces these values immediately (asynchronous) and discards the run.
- Sample latency:
  - Sample presented with `valid` at edge k.
  - Stage 1 holds it after edge k.
  - Counters, capture and `err_flag` update at edge k+1.
- `done` at edge k moves to DRAIN. `finished` is high after edge k+1 and counts are final at the same time.
- Back-to-back `valid` every cycle is supported with no stalls.
- `busy` rises the cycle after `start` is sampled.

## Test plan
- Add, passing vectors (a=1,b=3,cin=0,r=4,cout=0) then (a=10,b=12,cin=0,r=6,cout=1), then `done` → `pass_cnt`=2, `err_cnt`=0, `err_flag`=0, `finished`=1 two edges after `done`.
- Subtract, passing vectors (a=5,b=12,cin=1,r=9,cout=0) and (a=15,b=6,cin=1,r=9,cout=1) → `pass_cnt`=2, no errors.
- Injected error (a=5,b=2,cin=1,r=3,cout=0) followed by a different bad vector → `err_cnt`=2, capture holds a=5,b=2,cin=1,r=3,cout=0, `exp_r`=3, `exp_cout`=1.
- STOP_ON_ERR=1: bad vector followed by three good ones → HALT, `err_cnt`=1, `pass_cnt`=0, `finished`=1, `busy`=0.
- CNT_W=2: five passing vectors → `pass_cnt`=3, held at saturation.
- Reset and control corners:
  - `rst_n` low mid-run → all outputs 0 immediately.
  - After release, `start` together with `done` → RUN entered and `busy`=1.
  - `valid` samples while in IDLE → not counted.
